// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: two-port (A = CPU memory stage, B = debug/DMA loader)
// arbiter and sequencer for a single-port data RAM. Each access runs
// IDLE -> ACCESS -> RESP. The RAM samples ram_* on the negedge inside
// ACCESS. Read data is captured and acked on the following posedge.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, ties go
// to the port not granted last. When it is undefined, port A has fixed
// priority.
module data_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  state_t      state_q;
  port_t       grant_q;
  port_t       grant_d;
`ifdef ARB_ROUND_ROBIN_EN
  port_t       last_q;
`endif

  logic        ram_we_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_din_q;
  logic        a_ack_q, b_ack_q;
  logic [31:0] a_rdata_q, b_rdata_q;
  logic        a_err_q, b_err_q;
  logic        busy_q;

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        addr_oor;

  // Winner of the current IDLE sample: A unless only B asks (or, with
  // round robin, A was granted last and both ask).
  always_comb begin
    grant_d = PORT_A;
    if (b_req && !a_req) begin
      grant_d = PORT_B;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (a_req && b_req && (last_q == PORT_A)) begin
      grant_d = PORT_B;
    end
`endif
  end

  // Route the winner's command fields toward the RAM latch.
  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (grant_d == PORT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // Range check uses the latched address, so late requester changes cannot
  // affect the result.
  assign addr_oor = (ram_addr_q[31:ADDR_WIDTH] != '0);

  // Sequencer FSM with registered RAM controls and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= PORT_A;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= PORT_B;
`endif
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      a_ack_q    <= 1'b0;
      a_rdata_q  <= '0;
      a_err_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      b_rdata_q  <= '0;
      b_err_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            grant_q    <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= grant_d;
`endif
            ram_we_q   <= sel_we;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_wdata;
            busy_q     <= 1'b1;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          ram_we_q <= 1'b0;
          state_q  <= RESP;
          if (grant_q == PORT_A) begin
            a_ack_q   <= 1'b1;
            a_rdata_q <= addr_oor ? '0 : ram_dout;
            a_err_q   <= addr_oor;
          end else begin
            b_ack_q   <= 1'b1;
            b_rdata_q <= addr_oor ? '0 : ram_dout;
            b_err_q   <= addr_oor;
          end
        end
        RESP: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign a_ack    = a_ack_q;
  assign a_rdata  = a_rdata_q;
  assign a_err    = a_err_q;
  assign b_ack    = b_ack_q;
  assign b_rdata  = b_rdata_q;
  assign b_err    = b_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter. It contains a 32-word RAM, a transaction-level
// reference model and directed tests. Build with ARB_ROUND_ROBIN_EN defined
// to exercise the round-robin variant.
module tb_data_ram_arbiter;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        a_ack, a_err, b_ack, b_err, ram_we, busy;
  logic [31:0] a_rdata, b_rdata, ram_addr, ram_din;
  logic [31:0] ram_dout = '0;

  int errors = 0;
  int checks = 0;
  int cyc_tb = 0;

  data_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_tb++;

  // RAM in the environment. It acts on the negedge and ignores out-of-range
  // writes. Write-through: dout shows the written word.
  logic [31:0] tb_ram [32];
  always @(negedge clk) begin
    if (ram_we && (ram_addr >> AW) == 0) begin
      tb_ram[ram_addr[4:0]] = ram_din;
      ram_dout <= ram_din;
    end else begin
      ram_dout <= tb_ram[ram_addr[4:0]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. It tracks the number of clock edges since the last
  // grant. A grant is allowed 3 edges after the previous one. The ack
  // follows the grant by 1 edge. Busy is high for the grant edge and the
  // next edge.
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic [31:0] mmem [32];
  int          since = 10;
  bit          g_port = 0, last_p = 1;
  logic        l_we = 0;
  logic [31:0] l_addr = '0, l_wdata = '0, res = '0;
  logic        e_a_ack = 0, e_b_ack = 0, e_a_err = 0, e_b_err = 0;
  logic        e_ram_we = 0, e_busy = 0;
  logic [31:0] e_a_rdata = '0, e_b_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since = 10; g_port = 0; last_p = 1;
      l_we = 0; l_addr = '0; l_wdata = '0;
      e_a_ack = 0; e_b_ack = 0; e_a_err = 0; e_b_err = 0;
      e_a_rdata = '0; e_b_rdata = '0; e_ram_we = 0; e_busy = 0;
    end else begin
      if (since < 10) since++;
      e_a_ack = (since == 1) && (g_port == 0);
      e_b_ack = (since == 1) && (g_port == 1);
      if (since == 1) begin
        if (g_port == 0) begin e_a_rdata = res; e_a_err = (l_addr >> AW) != 0; end
        else             begin e_b_rdata = res; e_b_err = (l_addr >> AW) != 0; end
      end
      if (since >= 3 && (a_req || b_req)) begin
        g_port  = b_req && (!a_req || (RR && last_p == 0));
        last_p  = g_port;
        l_we    = g_port ? b_we : a_we;
        l_addr  = g_port ? b_addr : a_addr;
        l_wdata = g_port ? b_wdata : a_wdata;
        since   = 0;
        if ((l_addr >> AW) != 0) res = '0;
        else if (l_we)           res = l_wdata;
        else                     res = mmem[l_addr[4:0]];
      end
      e_ram_we = (since == 0) && l_we;
      e_busy   = (since <= 1);
    end
  end

  // A write counts only if the ACCESS negedge happens while reset is released.
  always @(negedge clk) begin
    if (rst_n && since == 0 && l_we && (l_addr >> AW) == 0)
      mmem[l_addr[4:0]] = l_wdata;
  end

  // Compare the DUT outputs against the model on every cycle.
  always @(posedge clk) begin
    #3;
    chk("ram_we",   {31'b0, ram_we}, {31'b0, e_ram_we});
    chk("ram_addr", ram_addr, l_addr);
    chk("ram_din",  ram_din,  l_wdata);
    chk("a_ack",    {31'b0, a_ack}, {31'b0, e_a_ack});
    chk("a_rdata",  a_rdata, e_a_rdata);
    chk("a_err",    {31'b0, a_err}, {31'b0, e_a_err});
    chk("b_ack",    {31'b0, b_ack}, {31'b0, e_b_ack});
    chk("b_rdata",  b_rdata, e_b_rdata);
    chk("b_err",    {31'b0, b_err}, {31'b0, e_b_err});
    chk("busy",     {31'b0, busy}, {31'b0, e_busy});
  end

  task automatic wait_ack(input bit port, input string nm, output int c);
    bit seen;
    seen = 0;
    c = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (port ? b_ack : a_ack) begin seen = 1; c = cyc_tb; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no ack expected ack within 20 cycles", nm);
    end
  endtask

  task automatic xfer(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] data, input string nm,
                      output logic [31:0] rd, output logic er);
    int c;
    @(posedge clk); #1;
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
    wait_ack(port, nm, c);
    rd = port ? b_rdata : a_rdata;
    er = port ? b_err : a_err;
    if (port) b_req = 0; else a_req = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          c1, c2;
    int          seq[$];
    bit [3:0]    exp_seq;
    bit          a_done, b_done, a_first;

    for (int i = 0; i < 32; i++) begin
      tb_ram[i] = 32'h1000_0000 + i;
      mmem[i]   = 32'h1000_0000 + i;
    end

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_addr",   ram_addr, 32'd0);
    @(posedge clk); #2 rst_n = 1;

    // 1: A write then back-to-back A read, both to address 3
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 32'd3; a_wdata = 32'hDEADBEEF;
    wait_ack(0, "t1_wr", c1);
    a_we = 0;
    wait_ack(0, "t1_rd", c2);
    chk("t1_rdata", a_rdata, 32'hDEADBEEF);
    chk("t1_err",   {31'b0, a_err}, 32'd0);
    chk("t1_ack_spacing", c2 - c1, 32'd3);
    a_req = 0;

    // 2: B out-of-range read and write
    xfer(1, 0, 32'h40, 32'h0, "t2_rd", rd, er);
    chk("t2_rd_rdata", rd, 32'h0);
    chk("t2_rd_err", {31'b0, er}, 32'd1);
    xfer(1, 1, 32'h40, 32'hBAD0BAD0, "t2_wr", rd, er);
    chk("t2_wr_err", {31'b0, er}, 32'd1);
    repeat (2) @(posedge clk);
    chk("t2_word0", tb_ram[0], 32'h1000_0000);

    // 3: both ports hold requests for four accesses
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 32'd1;
    b_req = 1; b_we = 0; b_addr = 32'd2;
    for (int i = 0; i < 40 && seq.size() < 4; i++) begin
      @(posedge clk); #1;
      if (a_ack) seq.push_back(0);
      if (b_ack) seq.push_back(1);
    end
    a_req = 0; b_req = 0;
    exp_seq = RR ? 4'b1010 : 4'b0000;
    chk("t3_count", seq.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_grant%0d", i), (i < seq.size()) ? seq[i] : 9, {31'b0, exp_seq[i]});
    repeat (2) @(posedge clk);

    // 4: A write to 5 races B read of 5. A's fields change during ACCESS.
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 32'd5; a_wdata = 32'h55AA55AA;
    b_req = 1; b_we = 0; b_addr = 32'd5;
    a_done = 0; b_done = 0; a_first = 0;
    for (int i = 0; i < 20 && !(a_done && b_done); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin a_addr = 32'd6; a_wdata = 32'hFFFFFFFF; end
      if (a_ack) begin a_done = 1; a_first = !b_done; a_req = 0; end
      if (b_ack) begin b_done = 1; chk("t4_b_rdata", b_rdata, 32'h55AA55AA); b_req = 0; end
    end
    chk("t4_both_acked", {30'b0, a_done, b_done}, 32'd3);
    chk("t4_a_first", {31'b0, a_first}, 32'd1);
    chk("t4_word5", tb_ram[5], 32'h55AA55AA);
    chk("t4_word6", tb_ram[6], 32'h1000_0006);

    // 5: reset during ACCESS, before the negedge
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 32'd7; a_wdata = 32'h77777777;
    @(posedge clk); #1;
    chk("t5_granted_we", {31'b0, ram_we}, 32'd1);
    rst_n = 0;
    #1;
    chk("t5_rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("t5_rst_busy",   {31'b0, busy}, 32'd0);
    a_req = 0;
    repeat (3) @(posedge clk);
    chk("t5_no_ack", {31'b0, a_ack}, 32'd0);
    #2 rst_n = 1;
    chk("t5_word7", tb_ram[7], 32'h1000_0007);
    chk("t5_busy_after", {31'b0, busy}, 32'd0);
    xfer(0, 0, 32'd7, 32'h0, "t5_rd", rd, er);
    chk("t5_fresh_rdata", rd, 32'h1000_0007);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 32; i++)
      chk($sformatf("mem%0d", i), tb_ram[i], mmem[i]);

    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
